// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the rotate-priority pick for rr_arbiter8.
package arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } arb_state_t;

  // First requester at or after ptr, wrapping modulo N; returns 0 when req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    win = '0;
    // Scan from the farthest offset down so the nearest requester overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// 3:8 one-hot decoder with enable; output is all-zero when en is low.
module dec3to8_en (
  input  logic [2:0] I,
  input  logic       en,
  output logic [7:0] Y
);

  // One-hot select of I, forced to zero while disabled.
  always_comb begin
    Y = '0;
    if (en) Y = 8'(1) << I;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Locking round-robin arbiter for 8 requesters.
// Optional build macro ARB_HOLD_LIMIT_EN: revoke a grant after MAX_HOLD consecutive
// GRANT cycles and pulse preempt; without it holds are unlimited and preempt is 0.
module rr_arbiter8
  import arb_pkg::*;
`ifdef ARB_HOLD_LIMIT_EN
#(
  parameter int unsigned MAX_HOLD = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] winner;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
`endif

  assign winner = rr_pick(req, ptr_q);

  // Next-state logic: pick in IDLE, lock in GRANT, one dead cycle in GAP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = winner;
          vld_d   = 1'b1;
          state_d = ST_GRANT;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end else begin
          vld_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          // Released owner drops to lowest priority.
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          state_d = ST_GAP;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_q == HoldW'(MAX_HOLD - 1)) begin
          vld_d     = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          preempt_d = 1'b1;
          state_d   = ST_GAP;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
`endif
      end
      ST_GAP: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Hold counter and preemption pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

  dec3to8_en u_dec (
    .I  (idx_q),
    .en (vld_q),
    .Y  (gnt)
  );

endmodule
